// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU with a valid/ready write-back port.
// Optional build macro DIV_EARLY_OUT_EN skips leading-zero dividend bits on entry to CALC.
module div_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_do_branch,
    input  logic                  ix_div_valid,
    input  logic [1:0]            ix_div_div_control,
    input  logic [REG_WIDTH-1:0]  ix_div_rd,
    input  logic [DATA_WIDTH-1:0] ix_div_rs1,
    input  logic [DATA_WIDTH-1:0] ix_div_rs2,
    output logic                  div_wb_valid,
    input  logic                  div_wb_ready,
    output logic [REG_WIDTH-1:0]  div_wb_rd,
    output logic [DATA_WIDTH-1:0] div_wb_result,
    output logic                  div_ix_done,
    output logic                  div_busy
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIXUP, RESULT} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         count_q, count_d;
    logic [W-1:0]          rem_q, rem_d;
    logic [W-1:0]          quo_q, quo_d;
    logic [W-1:0]          dvs_q, dvs_d;
    logic                  q_neg_q, q_neg_d;
    logic                  r_neg_q, r_neg_d;
    logic                  sel_rem_q, sel_rem_d;
    logic                  wb_valid_q, wb_valid_d;
    logic [REG_WIDTH-1:0]  wb_rd_q, wb_rd_d;
    logic [W-1:0]          wb_result_q, wb_result_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;

    logic                  signed_op, a_neg, b_neg, div_zero, ovf;
    logic [W-1:0]          a_mag, b_mag, q_fix, r_fix;
    logic [W:0]            shift_in, diff;

`ifdef DIV_EARLY_OUT_EN
    logic [CW:0]           lz;

    function automatic logic [CW:0] clz(input logic [W-1:0] v);
        logic [CW:0] n;
        n = (CW+1)'(W);
        for (int i = 0; i < W; i++)
            if (v[i]) n = (CW+1)'(W - 1 - i);
        return n;
    endfunction

    assign lz = clz(a_mag);
`endif

    always_comb begin
        signed_op = ~ix_div_div_control[0];
        a_neg     = signed_op & ix_div_rs1[W-1];
        b_neg     = signed_op & ix_div_rs2[W-1];
        a_mag     = a_neg ? -ix_div_rs1 : ix_div_rs1;
        b_mag     = b_neg ? -ix_div_rs2 : ix_div_rs2;
        div_zero  = (ix_div_rs2 == '0);
        ovf       = signed_op && (ix_div_rs1 == {1'b1, {(W-1){1'b0}}}) && (ix_div_rs2 == '1);
        // Remainder never reaches the divisor, so the shifted value fits in W+1 bits.
        shift_in  = {rem_q, quo_q[W-1]};
        diff      = shift_in - {1'b0, dvs_q};
        q_fix     = q_neg_q ? -quo_q : quo_q;
        r_fix     = r_neg_q ? -rem_q : rem_q;
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        sel_rem_d   = sel_rem_q;
        wb_valid_d  = wb_valid_q;
        wb_rd_d     = wb_rd_q;
        wb_result_d = wb_result_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                // The done-pulse cycle still belongs to the retiring op; new issue waits a cycle.
                if (ix_div_valid && !done_q && !wb_do_branch) begin
                    wb_rd_d   = ix_div_rd;
                    sel_rem_d = ix_div_div_control[1];
                    q_neg_d   = a_neg ^ b_neg;
                    r_neg_d   = a_neg;
                    if (div_zero) begin
                        wb_result_d = ix_div_div_control[1] ? ix_div_rs1 : '1;
                        wb_valid_d  = 1'b1;
                        state_d     = RESULT;
                    end else if (ovf) begin
                        wb_result_d = ix_div_div_control[1] ? '0 : ix_div_rs1;
                        wb_valid_d  = 1'b1;
                        state_d     = RESULT;
                    end else begin
                        rem_d   = '0;
                        dvs_d   = b_mag;
`ifdef DIV_EARLY_OUT_EN
                        quo_d   = a_mag << lz;
                        count_d = CW'(W - 1) - lz[CW-1:0];
                        state_d = (a_mag == '0) ? FIXUP : CALC;
`else
                        quo_d   = a_mag;
                        count_d = CW'(W - 1);
                        state_d = CALC;
`endif
                    end
                end
            end
            CALC: begin
                rem_d = diff[W] ? shift_in[W-1:0] : diff[W-1:0];
                quo_d = {quo_q[W-2:0], ~diff[W]};
                if (count_q == '0) state_d = FIXUP;
                else               count_d = count_q - 1'b1;
            end
            FIXUP: begin
                wb_result_d = sel_rem_q ? r_fix : q_fix;
                wb_valid_d  = 1'b1;
                state_d     = RESULT;
            end
            RESULT: begin
                if (div_wb_ready) begin
                    wb_valid_d = 1'b0;
                    done_d     = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A flush beats everything, including a same-cycle WB handshake.
        if (wb_do_branch) begin
            state_d    = IDLE;
            wb_valid_d = 1'b0;
            done_d     = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            sel_rem_q   <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_result_q <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            sel_rem_q   <= sel_rem_d;
            wb_valid_q  <= wb_valid_d;
            wb_rd_q     <= wb_rd_d;
            wb_result_q <= wb_result_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign div_wb_valid  = wb_valid_q;
    assign div_wb_rd     = wb_rd_q;
    assign div_wb_result = wb_result_q;
    assign div_ix_done   = done_q;
    assign div_busy      = busy_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst)
            assert (!(busy_q && ix_div_valid))
            else $error("div_unit: ix_div_valid asserted while busy");
    end
`endif

endmodule

// File: tb/tb_div_unit.sv
// Randomized self-checking bench for div_unit against an arithmetic reference model.
module tb_div_unit;
    localparam int W = 32;
    localparam int R = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          wb_do_branch;
    logic          ix_div_valid;
    logic [1:0]    ix_div_div_control;
    logic [R-1:0]  ix_div_rd;
    logic [W-1:0]  ix_div_rs1, ix_div_rs2;
    logic          div_wb_valid, div_wb_ready, div_ix_done, div_busy;
    logic [R-1:0]  div_wb_rd;
    logic [W-1:0]  div_wb_result;

    int n_chk  = 0;
    int n_fail = 0;

    div_unit #(.DATA_WIDTH(W), .REG_WIDTH(R)) dut (
        .clk(clk), .rst(rst), .wb_do_branch(wb_do_branch),
        .ix_div_valid(ix_div_valid), .ix_div_div_control(ix_div_div_control),
        .ix_div_rd(ix_div_rd), .ix_div_rs1(ix_div_rs1), .ix_div_rs2(ix_div_rs2),
        .div_wb_valid(div_wb_valid), .div_wb_ready(div_wb_ready),
        .div_wb_rd(div_wb_rd), .div_wb_result(div_wb_result),
        .div_ix_done(div_ix_done), .div_busy(div_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_res(input logic [1:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        int sa, sb;
        sa = a; sb = b;
        if (b == 0) return c[1] ? a : '1;
        if (!c[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return c[1] ? '0 : a;
        if (c[0]) return c[1] ? a % b : a / b;
        return c[1] ? W'(sa % sb) : W'(sa / sb);
    endfunction

    function automatic int ref_lat(input logic [1:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] m;
        int lz;
        if (b == 0) return 1;
        if (!c[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        m = (!c[0] && a[W-1]) ? -a : a;
        lz = 0;
        while (lz < W && m[W-1-lz] == 1'b0) lz++;
`ifdef DIV_EARLY_OUT_EN
        return W - lz + 2;
`else
        return W + 2;
`endif
    endfunction

    // Issue one op and drive it through retirement with `dly` cycles of WB back-pressure.
    task automatic run_op(input logic [1:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [R-1:0] rd, input int dly);
        int n;
        logic [W-1:0] exp;
        exp = ref_res(c, a, b);
        ix_div_valid = 1'b1; ix_div_div_control = c; ix_div_rd = rd;
        ix_div_rs1 = a; ix_div_rs2 = b;
        @(posedge clk); #1;
        ix_div_valid = 1'b0;
        chk("busy_after_issue", div_busy, 1'b1);
        n = 0;
        while (!div_wb_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk($sformatf("latency c=%0d a=%0h b=%0h", c, a, b), n + 1, ref_lat(c, a, b));
        chk($sformatf("result c=%0d a=%0h b=%0h", c, a, b), div_wb_result, exp);
        chk("rd", div_wb_rd, rd);
        for (int i = 0; i < dly; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", div_wb_valid, 1'b1);
            chk("hold_result", div_wb_result, exp);
            chk("hold_rd", div_wb_rd, rd);
            chk("no_early_done", div_ix_done, 1'b0);
        end
        div_wb_ready = 1'b1;
        @(posedge clk); #1;
        div_wb_ready = 1'b0;
        chk("valid_drop", div_wb_valid, 1'b0);
        chk("done_pulse", div_ix_done, 1'b1);
        @(posedge clk); #1;
        chk("done_single", div_ix_done, 1'b0);
        chk("idle_busy", div_busy, 1'b0);
    endtask

    initial begin
        logic [1:0]   c;
        logic [W-1:0] a, b;
        int seen;
        rst = 1'b0; wb_do_branch = 1'b0; ix_div_valid = 1'b0; ix_div_div_control = 2'b00;
        ix_div_rd = '0; ix_div_rs1 = '0; ix_div_rs2 = '0; div_wb_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", div_wb_valid, 1'b0);
        chk("rst_done", div_ix_done, 1'b0);
        chk("rst_busy", div_busy, 1'b0);
        chk("rst_rd", div_wb_rd, '0);
        chk("rst_result", div_wb_result, '0);
        rst = 1'b1;
        @(posedge clk); #1;

        run_op(2'b01, 100, 7, 3, 0);
        run_op(2'b00, 32'hFFFF_FF9C, 7, 4, 0);
        run_op(2'b10, 32'hFFFF_FF9C, 7, 5, 1);
        run_op(2'b11, 100, 7, 6, 0);
        run_op(2'b00, 5, 0, 7, 0);
        run_op(2'b10, 5, 0, 8, 0);
        run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 9, 0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 10, 0);
        run_op(2'b01, 1000, 10, 11, 5);
        run_op(2'b01, 1, 1, 0, 0);
        run_op(2'b01, 0, 9, 1, 0);

        // Flush mid-CALC: dividend with no leading zeros keeps CALC long in every build.
        ix_div_valid = 1'b1; ix_div_div_control = 2'b01; ix_div_rd = 12;
        ix_div_rs1 = 32'hF000_0000; ix_div_rs2 = 3;
        @(posedge clk); #1;
        ix_div_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        wb_do_branch = 1'b1;
        @(posedge clk); #1;
        wb_do_branch = 1'b0;
        chk("flush_busy", div_busy, 1'b0);
        chk("flush_valid", div_wb_valid, 1'b0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (div_wb_valid || div_ix_done) seen++;
        end
        chk("flush_quiet", seen, 0);
        run_op(2'b01, 9, 3, 13, 0);

        // Flush beats a same-cycle WB handshake.
        ix_div_valid = 1'b1; ix_div_div_control = 2'b00; ix_div_rd = 14;
        ix_div_rs1 = 5; ix_div_rs2 = 0;
        @(posedge clk); #1;
        ix_div_valid = 1'b0;
        chk("pre_flush_valid", div_wb_valid, 1'b1);
        div_wb_ready = 1'b1; wb_do_branch = 1'b1;
        @(posedge clk); #1;
        div_wb_ready = 1'b0; wb_do_branch = 1'b0;
        chk("flush_hs_valid", div_wb_valid, 1'b0);
        chk("flush_hs_done", div_ix_done, 1'b0);
        @(posedge clk); #1;
        chk("flush_hs_done2", div_ix_done, 1'b0);

        // Reset mid-CALC.
        ix_div_valid = 1'b1; ix_div_div_control = 2'b01; ix_div_rd = 15;
        ix_div_rs1 = 32'hFFFF_0000; ix_div_rs2 = 7;
        @(posedge clk); #1;
        ix_div_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        chk("mid_rst_valid", div_wb_valid, 1'b0);
        chk("mid_rst_done", div_ix_done, 1'b0);
        chk("mid_rst_busy", div_busy, 1'b0);
        chk("mid_rst_rd", div_wb_rd, '0);
        chk("mid_rst_result", div_wb_result, '0);
        @(posedge clk); #1;

        for (int k = 0; k < 40; k++) begin
            c = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                1: begin a = $urandom_range(0, 1000); b = $urandom_range(1, 50); end
                2: b = '0;
                3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                4: b = $urandom_range(1, 15) * (($urandom_range(0, 1) == 1) ? 1 : -1);
                5: a = '0;
                default: ;
            endcase
            run_op(c, a, b, R'($urandom), $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
